// File: rtl/execute_stage.sv
// LC-3 execute stage: ALU, address adder, dr/NZP decode, registered for mem/writeback/controller.
// Latency 1 cycle from IR/VSR inputs to registered outputs; sr1/sr2 are combinational.
// Backpressure: enable_execute=0 holds outputs, but clears NZP and exec_valid. Optional macro: EXECUTE_BYPASS_EN.
module execute_stage #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_execute,
  input  logic [15:0]       IR,
  input  logic [DATA_W-1:0] npc_in,
  input  logic [5:0]        E_control,
  input  logic [1:0]        W_Control_in,
  input  logic              Mem_Control_in,
  input  logic [DATA_W-1:0] VSR1,
  input  logic [DATA_W-1:0] VSR2,
`ifdef EXECUTE_BYPASS_EN
  input  logic              bypass_alu_1,
  input  logic              bypass_alu_2,
`endif
  output logic [2:0]        sr1,
  output logic [2:0]        sr2,
  output logic [DATA_W-1:0] aluout,
  output logic [DATA_W-1:0] pcout,
  output logic [2:0]        dr,
  output logic [DATA_W-1:0] M_Data,
  output logic [2:0]        NZP,
  output logic [15:0]       IR_Exec,
  output logic [1:0]        W_Control_out,
  output logic              Mem_Control_out,
  output logic              exec_valid
);

  logic [3:0]        opcode;
  logic [1:0]        alu_op;
  logic [1:0]        pcsel1;
  logic              pcsel2;
  logic              op2sel;
  logic [DATA_W-1:0] vsr1_eff, vsr2_eff, op2, alu_res, addr1, addr2;
  logic [2:0]        dr_new, nzp_new;

  logic [DATA_W-1:0] aluout_q, aluout_d, pcout_q, pcout_d, m_data_q, m_data_d;
  logic [2:0]        dr_q, dr_d, nzp_q, nzp_d;
  logic [15:0]       ir_exec_q, ir_exec_d;
  logic [1:0]        w_control_q, w_control_d;
  logic              mem_control_q, mem_control_d;
  logic              exec_valid_q, exec_valid_d;

  assign opcode = IR[15:12];
  assign alu_op = E_control[5:4];
  assign pcsel1 = E_control[3:2];
  assign pcsel2 = E_control[1];
  assign op2sel = E_control[0];

  // Register-file source addresses; stores read their data register through sr2
  always_comb begin
    sr1 = IR[8:6];
    if (opcode == 4'b0011 || opcode == 4'b0111 || opcode == 4'b1011) sr2 = IR[11:9];
    else                                                             sr2 = IR[2:0];
  end

  // Operand selection, with optional forwarding of the previous ALU result
  always_comb begin
`ifdef EXECUTE_BYPASS_EN
    vsr1_eff = bypass_alu_1 ? aluout_q : VSR1;
    vsr2_eff = bypass_alu_2 ? aluout_q : VSR2;
`else
    vsr1_eff = VSR1;
    vsr2_eff = VSR2;
`endif
    op2 = op2sel ? vsr2_eff : {{(DATA_W-5){IR[4]}}, IR[4:0]};
  end

  // ALU and address adder; both wrap modulo 2^DATA_W
  always_comb begin
    case (alu_op)
      2'd0:    alu_res = vsr1_eff + op2;
      2'd1:    alu_res = vsr1_eff & op2;
      2'd2:    alu_res = ~vsr1_eff;
      default: alu_res = '0;
    endcase
    addr1 = pcsel2 ? npc_in : vsr1_eff;
    case (pcsel1)
      2'd0:    addr2 = {{(DATA_W-11){IR[10]}}, IR[10:0]};
      2'd1:    addr2 = {{(DATA_W-9){IR[8]}}, IR[8:0]};
      2'd2:    addr2 = {{(DATA_W-6){IR[5]}}, IR[5:0]};
      default: addr2 = '0;
    endcase
  end

  // Destination register and branch mask from the opcode; unknown opcodes give 0
  always_comb begin
    dr_new  = 3'd0;
    nzp_new = 3'd0;
    case (opcode)
      4'b0001, 4'b0101, 4'b1001, 4'b0010,
      4'b0110, 4'b1010, 4'b1110: dr_new = IR[11:9];
      default:                   dr_new = 3'd0;
    endcase
    if (opcode == 4'b0000)      nzp_new = IR[11:9];
    else if (opcode == 4'b1100) nzp_new = 3'b111;
  end

  // Next-state: load on enable; on stall hold, except NZP/exec_valid drop so a branch fires once
  always_comb begin
    aluout_d      = aluout_q;
    pcout_d       = pcout_q;
    m_data_d      = m_data_q;
    dr_d          = dr_q;
    ir_exec_d     = ir_exec_q;
    w_control_d   = w_control_q;
    mem_control_d = mem_control_q;
    nzp_d         = 3'd0;
    exec_valid_d  = 1'b0;
    if (enable_execute) begin
      aluout_d      = alu_res;
      pcout_d       = addr1 + addr2;
      m_data_d      = vsr2_eff;
      dr_d          = dr_new;
      ir_exec_d     = IR;
      w_control_d   = W_Control_in;
      mem_control_d = Mem_Control_in;
      nzp_d         = nzp_new;
      exec_valid_d  = 1'b1;
    end
  end

  // State registers with synchronous active-low reset overriding enable
  always_ff @(posedge clock) begin
    if (!reset) begin
      aluout_q      <= '0;
      pcout_q       <= '0;
      m_data_q      <= '0;
      dr_q          <= '0;
      nzp_q         <= '0;
      ir_exec_q     <= '0;
      w_control_q   <= '0;
      mem_control_q <= 1'b0;
      exec_valid_q  <= 1'b0;
    end else begin
      aluout_q      <= aluout_d;
      pcout_q       <= pcout_d;
      m_data_q      <= m_data_d;
      dr_q          <= dr_d;
      nzp_q         <= nzp_d;
      ir_exec_q     <= ir_exec_d;
      w_control_q   <= w_control_d;
      mem_control_q <= mem_control_d;
      exec_valid_q  <= exec_valid_d;
    end
  end

  assign aluout          = aluout_q;
  assign pcout           = pcout_q;
  assign M_Data          = m_data_q;
  assign dr              = dr_q;
  assign NZP             = nzp_q;
  assign IR_Exec         = ir_exec_q;
  assign W_Control_out   = w_control_q;
  assign Mem_Control_out = mem_control_q;
  assign exec_valid      = exec_valid_q;

endmodule
